sm_hex_scan: RTL and testbench

Multiplexed hexadecimal display scanner for boards whose seven-segment digits share one segment bus and select a digit by anode/cathode enable. It sits downstream of the core's register-debug read port (`regData`). It time-multiplexes up to eight nibbles of a 32-bit value onto the shared bus. It inserts a blanking gap between digits against ghosting and latches the value once per frame so a frame never shows a mixed value.

---
 rtl/sm_display_pkg.sv | 16 +
 rtl/sm_hex_display.sv | 13 +
 rtl/sm_hex_scan.sv | 105 ++++++++++
 tb/tb_sm_hex_scan.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sm_display_pkg.sv
// sm_display_pkg: shared scan state encoding and segment bus layout for the
// multiplexed seven-segment display blocks.
package sm_display_pkg;
    typedef enum logic {SCAN_BLANK = 1'b0, SCAN_SHOW = 1'b1} scan_state_t;
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;
    localparam int SEG_W  = 8;
    // Active-high form; pin polarity is applied at the top level.
    localparam logic [SEG_W-1:0] SEG_OFF = '0;
endpackage

// File: rtl/sm_hex_display.sv
// sm_hex_display: active-high nibble-to-seven-segment decoder, bit order g..a.
module sm_hex_display
    import sm_display_pkg::*;
(
    input  logic [3:0]        i_nib,
    output logic [SEG_DP-1:0] o_seg
);
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    assign o_seg = GLYPH[i_nib];
endmodule

// File: rtl/sm_hex_scan.sv
// sm_hex_scan: multiplexed hex scanner with inter-digit blanking and per-frame latch.
// Leading-zero blanking is enabled by defining SM_HEX_SCAN_LZB_EN.
module sm_hex_scan
    import sm_display_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int PRESCALE   = 50000,
    parameter int BLANK      = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       value,
    input  logic [7:0]        dots,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] anode,
    output logic              frame
);
    localparam int CMAX = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    scan_state_t       r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [IW-1:0]     r_idx, w_idx_nxt;
    logic [31:0]       r_shadow_val;
    logic [7:0]        r_shadow_dots;
    logic              r_frame;
    logic              w_blank_end, w_show_end, w_load;
    logic [3:0]        w_nib;
    logic [6:0]        w_glyph;
    logic [DIGITS-1:0] w_anode;
    logic [SEG_W-1:0]  w_seg;

`ifdef SM_HEX_SCAN_LZB_EN
    logic [DIGITS-1:0] r_lz, w_lz_nxt;
    logic              w_zero;

    // Mask every digit above the most significant non-zero nibble; digit 0 stays lit.
    always_comb begin
        w_lz_nxt = '0;
        w_zero   = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_zero      = w_zero && (value[4*i +: 4] == 4'h0);
            w_lz_nxt[i] = w_zero;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SCAN_BLANK;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shadow_val  <= '0;
            r_shadow_dots <= '0;
            r_frame       <= 1'b0;
`ifdef SM_HEX_SCAN_LZB_EN
            r_lz          <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_frame <= w_load;
            if (w_load) begin
                r_shadow_val  <= value;
                r_shadow_dots <= dots;
`ifdef SM_HEX_SCAN_LZB_EN
                r_lz          <= w_lz_nxt;
`endif
            end
        end
    end

    // The shadows are reloaded only when entering digit 0, so a frame never tears.
    always_comb begin
        w_blank_end = (r_state == SCAN_BLANK) && (r_cnt == CW'(BLANK - 1));
        w_show_end  = (r_state == SCAN_SHOW) && (r_cnt == CW'(PRESCALE - 1));
        w_load      = w_blank_end && (r_idx == '0);
        w_state_nxt = w_blank_end ? SCAN_SHOW : w_show_end ? SCAN_BLANK : r_state;
        w_cnt_nxt   = (w_blank_end || w_show_end) ? '0 : r_cnt + 1'b1;
        w_idx_nxt   = !w_show_end ? r_idx : (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end

    assign w_nib = r_shadow_val[{r_idx, 2'b00} +: 4];

    sm_hex_display u_dec (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    always_comb begin
        w_anode = (r_state == SCAN_SHOW) ? (DIGITS'(1) << r_idx) : '0;
        w_seg   = (r_state == SCAN_SHOW) ? {r_shadow_dots[r_idx], w_glyph} : SEG_OFF;
`ifdef SM_HEX_SCAN_LZB_EN
        if ((r_state == SCAN_SHOW) && r_lz[r_idx])
            w_seg[SEG_DP-1:0] = '0;
`endif
        anode = (ACTIVE_LOW != 0) ? ~w_anode : w_anode;
        seg   = (ACTIVE_LOW != 0) ? ~w_seg : w_seg;
    end

    assign frame = r_frame;
endmodule

// File: tb/tb_sm_hex_scan.sv
// tb_sm_hex_scan: scoreboard bench; a frame-position model predicts every cycle of
// anode/seg/frame for DIGITS=8, PRESCALE=4, BLANK=1, active-low outputs.
module tb_sm_hex_scan;
    typedef struct packed {
        logic [7:0] an;
        logic [7:0] sg;
        logic       fr;
    } exp_t;

    localparam logic [6:0] GL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] value;
    logic [7:0]  dots;
    logic [7:0]  seg;
    logic [7:0]  anode;
    logic        frame;

    exp_t        q[$];
    logic [31:0] mval;
    logic [7:0]  mdots;
    int          t;
    int          n_cmp = 0;
    int          n_err = 0;

    sm_hex_scan #(
        .DIGITS     (8),
        .PRESCALE   (4),
        .BLANK      (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .dots  (dots),
        .seg   (seg),
        .anode (anode),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    // Expected outputs for cycle tc of a frame: 40-cycle period, 5 cycles per digit, first dark.
    function automatic exp_t model(input int tc);
        int          p = tc % 40;
        int          k = p / 5;
        logic [31:0] sh;
        exp_t        e;
        e.an = 8'hFF;
        e.sg = 8'hFF;
        e.fr = 1'b0;
        if (p % 5 != 0) begin
            sh   = mval >> (4 * k);
            e.an = ~(8'h01 << k);
            e.sg = {~mdots[k], GL[sh[3:0]]};
`ifdef SM_HEX_SCAN_LZB_EN
            if (k > 0 && sh == 32'h0)
                e.sg[6:0] = 7'h7F;
`endif
            e.fr = (p == 1);
        end
        return e;
    endfunction

    task automatic popcmp();
        exp_t e;
        e = q.pop_front();
        chk("anode", {24'h0, anode}, {24'h0, e.an});
        chk("seg", {24'h0, seg}, {24'h0, e.sg});
        chk("frame", {31'h0, frame}, {31'h0, e.fr});
    endtask

    // Inputs now present are what the DUT samples at the coming edge.
    task automatic step();
        if (t % 40 == 0) begin
            mval  = value;
            mdots = dots;
        end
        t++;
        q.push_back(model(t));
        @(negedge clk);
        popcmp();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        t = 0;
        q.push_back(model(0));
        @(negedge clk);
        popcmp();
    endtask

    initial begin
        rst_n = 1'b0;
        value = 32'h1234_5678;
        dots  = 8'h00;
        mval  = '0;
        mdots = '0;
        t     = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_anode", {24'h0, anode}, 32'hFF);
        chk("rst_seg", {24'h0, seg}, 32'hFF);
        chk("rst_frame", {31'h0, frame}, 32'h0);
        release_reset();
        run(80);
        while (t % 40 != 16)
            step();
        value = 32'hFFFF_FFFF;
        run(64);
        dots = 8'h05;
        run(80);
        value = 32'h0000_00A0;
        dots  = 8'h00;
        run(80);
        value = 32'h0000_0000;
        run(80);
        value = 32'hCAFE_0123;
        dots  = 8'h81;
        run(80);
        while (t % 40 != 27)
            step();
        rst_n = 1'b0;
        #1;
        chk("async_anode", {24'h0, anode}, 32'hFF);
        chk("async_seg", {24'h0, seg}, 32'hFF);
        chk("async_frame", {31'h0, frame}, 32'h0);
        value = 32'h89AB_CDEF;
        dots  = 8'h20;
        release_reset();
        run(80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
